// File: rtl/mc_ctrl_pkg.sv
// Shared state encoding, instruction constants and ALU codes for the mc_ctrl
// multicycle controller, plus the per-state Moore output table.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_ADDR   = 4'd2,
      S_MEM_RD = 4'd3,
      S_MEM_WR = 4'd4,
      S_WB_MEM = 4'd5,
      S_EXEC_R = 4'd6,
      S_EXEC_I = 4'd7,
      S_WB_ALU = 4'd8,
      S_BRANCH = 4'd9,
      S_JUMP   = 4'd10
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   // fetch and pc_cond are qualifiers: FETCH strobes wait for memory, BRANCH
   // writes the PC only when the ALU reports equality.
   typedef struct packed {
      logic       pc_write;
      logic       pc_cond;
      logic       fetch;
      logic [1:0] pc_src;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic [3:0] alu_ctrl;
   } ctrl_t;

   function automatic ctrl_t state_ctrl(input state_t s, input logic rtype,
                                        input logic [3:0] alu_r);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.fetch    = 1'b1;
            c.mem_read = 1'b1;
         end
         S_ADDR, S_EXEC_I: begin
            c.alu_src  = 1'b1;
            c.alu_ctrl = ALU_ADD;
         end
         S_EXEC_R: c.alu_ctrl = alu_r;
         S_MEM_RD: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
         end
         S_MEM_WR: begin
            c.mem_write = 1'b1;
            c.i_or_d    = 1'b1;
         end
         S_WB_MEM: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_WB_ALU: begin
            c.reg_write = 1'b1;
            c.reg_dst   = rtype;
         end
         S_BRANCH: begin
            c.pc_cond  = 1'b1;
            c.pc_src   = 2'd1;
            c.alu_ctrl = ALU_SUB;
         end
         S_JUMP: begin
            c.pc_write = 1'b1;
            c.pc_src   = 2'd2;
         end
         default: ;
      endcase
      return c;
   endfunction

   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// R-type funct decoder: maps funct to an alu_ctrl code and flags legal functs.
module alu_dec
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] funct,
   output logic [3:0] alu_ctrl,
   output logic       funct_ok
);

   always_comb begin
      alu_ctrl = ALU_AND;
      funct_ok = 1'b1;
      case (funct)
         FN_ADD:  alu_ctrl = ALU_ADD;
         FN_SUB:  alu_ctrl = ALU_SUB;
         FN_AND:  alu_ctrl = ALU_AND;
         FN_OR:   alu_ctrl = ALU_OR;
         FN_SLT:  alu_ctrl = ALU_SLT;
         default: funct_ok = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control FSM. Define MC_CTRL_MEM_WAIT_EN to make
// FETCH/MEM_RD/MEM_WR wait on mem_ready with a MEM_TIMEOUT abandon counter.
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       alu_src,
   output logic       mem_to_reg,
   output logic [3:0] alu_ctrl,
   output logic [3:0] state,
   output logic       illegal,
   output logic       mem_timeout
);

   state_t     state_q, state_n;
   ctrl_t      ctrl_q, ctrl_n;
   logic       is_rtype_q, is_lw_q, rtype_n;
   logic [3:0] dec_alu;
   logic       dec_ok;
   logic       mem_ok, illegal_c, timeout_c;

   alu_dec u_alu_dec (
      .funct    (funct),
      .alu_ctrl (dec_alu),
      .funct_ok (dec_ok)
   );

`ifdef MC_CTRL_MEM_WAIT_EN
   localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

   logic [CNT_W-1:0] wait_cnt;

   assign mem_ok    = mem_ready;
   assign timeout_c = is_mem_state(state_q) && !mem_ready &&
                      (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

   // Counts consecutive not-ready cycles within one memory state only.
   always_ff @(posedge clk) begin
      if (rst)
         wait_cnt <= '0;
      else if ((state_n != state_q) || timeout_c || mem_ready || !is_mem_state(state_q))
         wait_cnt <= '0;
      else
         wait_cnt <= wait_cnt + CNT_W'(1);
   end
`else
   logic unused_mem;

   assign unused_mem = mem_ready ^ (MEM_TIMEOUT != 0);
   assign mem_ok     = 1'b1;
   assign timeout_c  = 1'b0;
`endif

   always_comb begin
      state_n   = state_q;
      illegal_c = 1'b0;
      case (state_q)
         S_FETCH:  if (mem_ok) state_n = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE: begin
                  if (dec_ok) begin
                     state_n = S_EXEC_R;
                  end else begin
                     state_n   = S_FETCH;
                     illegal_c = 1'b1;
                  end
               end
               OP_LW, OP_SW: state_n = S_ADDR;
               OP_ADDI:      state_n = S_EXEC_I;
               OP_BEQ:       state_n = S_BRANCH;
               OP_J:         state_n = S_JUMP;
               default: begin
                  state_n   = S_FETCH;
                  illegal_c = 1'b1;
               end
            endcase
         end
         S_ADDR:   state_n = is_lw_q ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: if (mem_ok) state_n = S_WB_MEM;
         S_MEM_WR: if (mem_ok) state_n = S_FETCH;
         S_EXEC_R, S_EXEC_I: state_n = S_WB_ALU;
         default:  state_n = S_FETCH;
      endcase
      if (timeout_c)
         state_n = S_FETCH;
   end

   // Outputs for the next state are precomputed so they are registered and
   // stay constant for the whole of each state.
   assign rtype_n = (state_q == S_DECODE) ? (opcode == OP_RTYPE) : is_rtype_q;
   assign ctrl_n  = state_ctrl(state_n, rtype_n, dec_alu);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         ctrl_q  <= state_ctrl(S_FETCH, 1'b0, ALU_AND);
      end else begin
         state_q <= state_n;
         ctrl_q  <= ctrl_n;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == S_DECODE) begin
         is_rtype_q <= (opcode == OP_RTYPE);
         is_lw_q    <= (opcode == OP_LW);
      end
   end

   // Reset masks every output in the cycle it is asserted.
   assign pc_write    = !rst && (ctrl_q.pc_write || (ctrl_q.fetch && mem_ok) ||
                                 (ctrl_q.pc_cond && zero));
   assign ir_write    = !rst && ctrl_q.fetch && mem_ok;
   assign pc_src      = rst ? 2'b00 : ctrl_q.pc_src;
   assign i_or_d      = !rst && ctrl_q.i_or_d;
   assign mem_read    = !rst && ctrl_q.mem_read;
   assign mem_write   = !rst && ctrl_q.mem_write;
   assign reg_write   = !rst && ctrl_q.reg_write;
   assign reg_dst     = !rst && ctrl_q.reg_dst;
   assign alu_src     = !rst && ctrl_q.alu_src;
   assign mem_to_reg  = !rst && ctrl_q.mem_to_reg;
   assign alu_ctrl    = rst ? 4'b0000 : ctrl_q.alu_ctrl;
   assign state       = rst ? S_FETCH : state_q;
   assign illegal     = !rst && illegal_c;
   assign mem_timeout = !rst && timeout_c;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized self-checking bench for mc_ctrl against a per-instruction
// state-sequence and output-table reference model.
module tb_mc_ctrl;
   import mc_ctrl_pkg::*;

   localparam int TMO = 15;
`ifdef MC_CTRL_MEM_WAIT_EN
   localparam bit WAIT_EN = 1'b1;
`else
   localparam bit WAIT_EN = 1'b0;
`endif

   typedef enum int {C_LW, C_SW, C_R, C_ADDI, C_BEQ, C_J, C_ILL} cls_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = '0, funct = '0;
   logic       zero = 1'b0, mem_ready = 1'b0;
   logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write;
   logic       reg_dst, alu_src, mem_to_reg, illegal, mem_timeout;
   logic [1:0] pc_src;
   logic [3:0] alu_ctrl, state;
   logic [16:0] outs;

   int n_vec = 0;
   int n_bad = 0;
   state_t exp_seq[$];

   mc_ctrl #(.MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
      .alu_src(alu_src), .mem_to_reg(mem_to_reg), .alu_ctrl(alu_ctrl),
      .state(state), .illegal(illegal), .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   assign outs = {pc_write, pc_src, i_or_d, mem_read, mem_write, ir_write, reg_write,
                  reg_dst, alu_src, mem_to_reg, alu_ctrl, illegal, mem_timeout};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] ref_alu(input logic [5:0] fn);
      case (fn)
         6'b100000: return 4'b0010;
         6'b100010: return 4'b0110;
         6'b100100: return 4'b0000;
         6'b100101: return 4'b0001;
         6'b101010: return 4'b0111;
         default:   return 4'b0000;
      endcase
   endfunction

   // Expected outputs per state, straight from the controller's output table.
   function automatic logic [16:0] exp_outs(input state_t s, input bit rtype,
                                            input logic [3:0] alu_r, input bit z,
                                            input bit mr, input bit ill, input bit tmo);
      logic pw, ir, rd_s, wr_s, rw, rd, as, m2r, iod, ill_o;
      logic [1:0] ps;
      logic [3:0] ac;
      bit rdy;
      {pw, ir, rd_s, wr_s, rw, rd, as, m2r, iod, ill_o} = '0;
      ps  = 2'd0;
      ac  = 4'd0;
      rdy = WAIT_EN ? mr : 1'b1;
      case (s)
         S_FETCH:  begin rd_s = 1; pw = rdy; ir = rdy; end
         S_DECODE: ill_o = ill;
         S_ADDR, S_EXEC_I: begin as = 1; ac = 4'b0010; end
         S_EXEC_R: ac = alu_r;
         S_MEM_RD: begin rd_s = 1; iod = 1; end
         S_MEM_WR: begin wr_s = 1; iod = 1; end
         S_WB_MEM: begin rw = 1; m2r = 1; end
         S_WB_ALU: begin rw = 1; rd = rtype; end
         S_BRANCH: begin ac = 4'b0110; ps = 2'd1; pw = z; end
         S_JUMP:   begin ps = 2'd2; pw = 1; end
         default: ;
      endcase
      return {pw, ps, iod, rd_s, wr_s, ir, rw, rd, as, m2r, ac, ill_o, tmo};
   endfunction

   task automatic build_seq(input cls_t c);
      exp_seq.delete();
      exp_seq.push_back(S_FETCH);
      exp_seq.push_back(S_DECODE);
      case (c)
         C_LW:   begin exp_seq.push_back(S_ADDR); exp_seq.push_back(S_MEM_RD); exp_seq.push_back(S_WB_MEM); end
         C_SW:   begin exp_seq.push_back(S_ADDR); exp_seq.push_back(S_MEM_WR); end
         C_R:    begin exp_seq.push_back(S_EXEC_R); exp_seq.push_back(S_WB_ALU); end
         C_ADDI: begin exp_seq.push_back(S_EXEC_I); exp_seq.push_back(S_WB_ALU); end
         C_BEQ:  exp_seq.push_back(S_BRANCH);
         C_J:    exp_seq.push_back(S_JUMP);
         default: ;
      endcase
   endtask

   // One clock of stimulus, then compare state and outputs mid-cycle.
   task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic r,
                       input logic mr, input int zmode, input state_t s,
                       input bit rtype, input bit ill, input bit tmo);
      @(negedge clk);
      opcode    = op;
      funct     = fn;
      rst       = r;
      mem_ready = mr;
      zero      = (zmode < 0) ? 1'($urandom_range(0, 1)) : zmode[0];
      #1;
      if (r) begin
         check("rst_state", 32'(state), 32'(S_FETCH));
         check("rst_outs", 32'(outs), 32'd0);
      end else begin
         check($sformatf("state@%s", s.name()), 32'(state), 32'(s));
         check($sformatf("outs@%s", s.name()), 32'(outs),
               32'(exp_outs(s, rtype, ref_alu(fn), zero, mr, ill, tmo)));
      end
   endtask

   task automatic run_instr(input cls_t c, input logic [5:0] op, input logic [5:0] fn,
                            input int rst_at, input int zmode);
      logic mr;
      build_seq(c);
      for (int i = 0; i < exp_seq.size(); i++) begin
         mr = WAIT_EN ? 1'b1 : 1'($urandom_range(0, 1));
         step(op, fn, (i == rst_at), mr, zmode, exp_seq[i], (c == C_R), (c == C_ILL), 1'b0);
         if (i == rst_at) break;
      end
   endtask

`ifdef MC_CTRL_MEM_WAIT_EN
   task automatic run_lw_wait(input int k);
      bit timed = 1'b0;
      step(6'b100011, 6'd0, 1'b0, 1'b0, -1, S_FETCH, 1'b0, 1'b0, 1'b0);
      step(6'b100011, 6'd0, 1'b0, 1'b1, -1, S_FETCH, 1'b0, 1'b0, 1'b0);
      step(6'b100011, 6'd0, 1'b0, 1'b1, -1, S_DECODE, 1'b0, 1'b0, 1'b0);
      step(6'b100011, 6'd0, 1'b0, 1'b1, -1, S_ADDR, 1'b0, 1'b0, 1'b0);
      for (int j = 0; j < k; j++) begin
         step(6'b100011, 6'd0, 1'b0, 1'b0, -1, S_MEM_RD, 1'b0, 1'b0, (j == TMO - 1));
         if (j == TMO - 1) begin
            timed = 1'b1;
            break;
         end
      end
      if (timed) begin
         step(6'b100011, 6'd0, 1'b0, 1'b1, -1, S_FETCH, 1'b0, 1'b0, 1'b0);
         step(6'b100011, 6'd0, 1'b0, 1'b1, -1, S_DECODE, 1'b0, 1'b0, 1'b0);
      end else begin
         step(6'b100011, 6'd0, 1'b0, 1'b1, -1, S_MEM_RD, 1'b0, 1'b0, 1'b0);
         step(6'b100011, 6'd0, 1'b0, 1'b1, -1, S_WB_MEM, 1'b0, 1'b0, 1'b0);
      end
   endtask
`endif

   initial begin
      logic [5:0] legal_fn [5];
      logic [5:0] op, fn;
      cls_t c;
      int rst_at;
      legal_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

      // Reset held with busy inputs: everything must read as zero / FETCH.
      for (int i = 0; i < 2; i++)
         step(6'b000100, 6'b100010, 1'b1, 1'b1, 1, S_FETCH, 1'b0, 1'b0, 1'b0);

      run_instr(C_LW,   6'b100011, 6'h15, -1, -1);
      run_instr(C_R,    6'b000000, 6'b100010, -1, -1);
      run_instr(C_BEQ,  6'b000100, 6'h00, -1, 1);
      run_instr(C_BEQ,  6'b000100, 6'h00, -1, 0);
      run_instr(C_ILL,  6'b111111, 6'h00, -1, -1);
      run_instr(C_ILL,  6'b000000, 6'b000111, -1, -1);
      run_instr(C_SW,   6'b101011, 6'h00, 3, -1);
      run_instr(C_J,    6'b000010, 6'h3f, -1, -1);
      run_instr(C_ADDI, 6'b001000, 6'b100010, -1, -1);
      for (int i = 0; i < 5; i++)
         run_instr(C_R, 6'b000000, legal_fn[i], -1, -1);

`ifdef MC_CTRL_MEM_WAIT_EN
      run_lw_wait(3);
      run_lw_wait(TMO);
`endif

      for (int n = 0; n < 300; n++) begin
         c  = cls_t'($urandom_range(0, 6));
         fn = 6'($urandom_range(0, 63));
         case (c)
            C_LW:   op = 6'b100011;
            C_SW:   op = 6'b101011;
            C_ADDI: op = 6'b001000;
            C_BEQ:  op = 6'b000100;
            C_J:    op = 6'b000010;
            C_R: begin
               op = 6'b000000;
               fn = legal_fn[$urandom_range(0, 4)];
            end
            default: begin
               if ($urandom_range(0, 1) == 0) begin
                  op = 6'b000000;
                  do fn = 6'($urandom_range(0, 63));
                  while (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
               end else begin
                  do op = 6'($urandom_range(0, 63));
                  while (op inside {6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b000010});
               end
            end
         endcase
         rst_at = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1;
         run_instr(c, op, fn, rst_at, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
